// File: rtl/demux_1to2.sv
// 1-to-2 demultiplexer with registered outputs, per-channel valid flags and
// saturating per-channel transfer counters.
//
// Optional build macro: DEMUX_COMB_BYPASS_EN
//   Defined   : d0/d1 are driven combinationally from y/sel with zero latency
//               and are not reset. Valid flags and counters stay registered.
//   Undefined : d0/d1 are registered with exactly one cycle of latency.
module demux_1to2 #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] y,
    input  logic             sel,
    input  logic             in_valid,
    input  logic             clear_cnt,
    output logic [WIDTH-1:0] d0,
    output logic [WIDTH-1:0] d1,
    output logic             d0_valid,
    output logic             d1_valid,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);

    // All-ones is the saturation ceiling of each counter.
    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

    // ------------------------------------------------------------------
    // Valid flags
    // ------------------------------------------------------------------
    logic d0_valid_d, d0_valid_q;
    logic d1_valid_d, d1_valid_q;

    // A transfer is flagged on exactly the channel sel points to.
    always_comb begin
        d0_valid_d = in_valid & ~sel;
        d1_valid_d = in_valid & sel;
    end

    // Valid flag state, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d0_valid_q <= 1'b0;
            d1_valid_q <= 1'b0;
        end else begin
            d0_valid_q <= d0_valid_d;
            d1_valid_q <= d1_valid_d;
        end
    end

    assign d0_valid = d0_valid_q;
    assign d1_valid = d1_valid_q;

    // ------------------------------------------------------------------
    // Transfer counters
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] cnt0_d, cnt0_q;
    logic [CNT_W-1:0] cnt1_d, cnt1_q;

    // Clear wins over a same-cycle increment; increments stick at CntMax.
    always_comb begin
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        if (clear_cnt) begin
            cnt0_d = '0;
            cnt1_d = '0;
        end else begin
            if (d0_valid_d && (cnt0_q != CntMax)) begin
                cnt0_d = cnt0_q + 1'b1;
            end
            if (d1_valid_d && (cnt1_q != CntMax)) begin
                cnt1_d = cnt1_q + 1'b1;
            end
        end
    end

    // Counter state, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
        end
    end

    assign cnt0 = cnt0_q;
    assign cnt1 = cnt1_q;

    // ------------------------------------------------------------------
    // Data path
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] d0_d;
    logic [WIDTH-1:0] d1_d;

    // Route y to the selected channel; the other channel is forced to zero.
    // Routing ignores in_valid.
    always_comb begin
        d0_d = sel ? '0 : y;
        d1_d = sel ? y : '0;
    end

`ifdef DEMUX_COMB_BYPASS_EN
    // Zero-latency data path, deliberately outside reset control.
    assign d0 = d0_d;
    assign d1 = d1_d;
`else
    logic [WIDTH-1:0] d0_q;
    logic [WIDTH-1:0] d1_q;

    // Registered data path; reset drops any in-flight word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d0_q <= '0;
            d1_q <= '0;
        end else begin
            d0_q <= d0_d;
            d1_q <= d1_d;
        end
    end

    assign d0 = d0_q;
    assign d1 = d1_q;
`endif

endmodule

// File: tb/tb_demux_1to2.sv
// Scoreboard bench for demux_1to2: a 16-bit-counter instance and a 2-bit-counter
// instance share stimulus; expected outputs are queued at drive time.
`timescale 1ns/1ps
module tb_demux_1to2;

`ifdef DEMUX_COMB_BYPASS_EN
    localparam bit Byp = 1'b1;
`else
    localparam bit Byp = 1'b0;
`endif

    // {d0,d1,v0,v1,cnt0[16],cnt1[16], s_d0,s_d1,s_v0,s_v1,s_cnt0[2],s_cnt1[2]}
    typedef logic [43:0] exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [0:0]  y = 1'b0;
    logic        sel = 1'b0;
    logic        in_valid = 1'b0;
    logic        clear_cnt = 1'b0;

    logic [0:0]  d0, d1, s_d0, s_d1;
    logic        d0_valid, d1_valid, s_v0, s_v1;
    logic [15:0] cnt0, cnt1;
    logic [1:0]  s_cnt0, s_cnt1;

    exp_t        sb_q[$];
    exp_t        exp_v;
    exp_t        got_v;
    logic [15:0] m_c0, m_c1;
    logic [1:0]  m_s0, m_s1;
    int          n_checks = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    demux_1to2 #(.WIDTH(1), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .y(y), .sel(sel), .in_valid(in_valid),
        .clear_cnt(clear_cnt), .d0(d0), .d1(d1), .d0_valid(d0_valid),
        .d1_valid(d1_valid), .cnt0(cnt0), .cnt1(cnt1)
    );

    demux_1to2 #(.WIDTH(1), .CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .y(y), .sel(sel), .in_valid(in_valid),
        .clear_cnt(clear_cnt), .d0(s_d0), .d1(s_d1), .d0_valid(s_v0),
        .d1_valid(s_v1), .cnt0(s_cnt0), .cnt1(s_cnt1)
    );

    function automatic exp_t observe();
        return {d0, d1, d0_valid, d1_valid, cnt0, cnt1, s_d0, s_d1, s_v0, s_v1, s_cnt0, s_cnt1};
    endfunction

    function automatic exp_t pack_exp(logic yy, logic ss, logic vv);
        logic e0, e1;
        e0 = ss ? 1'b0 : yy;
        e1 = ss ? yy : 1'b0;
        return {e0, e1, vv & ~ss, vv & ss, m_c0, m_c1, e0, e1, vv & ~ss, vv & ss, m_s0, m_s1};
    endfunction

    // Drive one cycle of stimulus, advance the model, queue the expectation,
    // and return 1 ns after the capturing edge.
    task automatic drive(input logic yy, input logic ss, input logic vv, input logic cc);
        y = yy;
        sel = ss;
        in_valid = vv;
        clear_cnt = cc;
        if (cc) begin
            m_c0 = '0; m_c1 = '0; m_s0 = '0; m_s1 = '0;
        end else if (vv) begin
            if (!ss) begin
                if (m_c0 != 16'hFFFF) m_c0 = m_c0 + 16'd1;
                if (m_s0 != 2'd3) m_s0 = m_s0 + 2'd1;
            end else begin
                if (m_c1 != 16'hFFFF) m_c1 = m_c1 + 16'd1;
                if (m_s1 != 2'd3) m_s1 = m_s1 + 2'd1;
            end
        end
        sb_q.push_back(pack_exp(yy, ss, vv));
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_c0 = '0; m_c1 = '0; m_s0 = '0; m_s1 = '0;
        sb_q.delete();
    endtask

    task automatic test_reset();
        y = 1'b1; sel = 1'b1; in_valid = 1'b0; clear_cnt = 1'b0;
        #1 rst = 1'b1;
        #1;
        model_reset();
        exp_v = pack_exp(1'b1 & Byp, 1'b1, 1'b0);
        exp_v[41:40] = 2'b00;
        exp_v[5:4] = 2'b00;
        got_v = observe();
        n_checks++;
        if (got_v !== exp_v) begin
            $display("FAIL reset_async: got %h want %h", got_v, exp_v);
            n_fail++;
        end
        #1 rst = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        exp_v = sb_q.pop_front();
        got_v = observe();
        n_checks++;
        if (got_v !== exp_v) begin
            $display("FAIL reset_first_edge: got %h want %h", got_v, exp_v);
            n_fail++;
        end
    endtask

    task automatic test_truth_table();
        logic [1:0] tt;
        for (int i = 0; i < 4; i++) begin
            tt = 2'(i);
            drive(tt[0], tt[1], 1'b1, 1'b0);
            exp_v = sb_q.pop_front();
            got_v = observe();
            n_checks++;
            if (got_v !== exp_v) begin
                $display("FAIL truth_table[%0d]: got %h want %h", i, got_v, exp_v);
                n_fail++;
            end
        end
        n_checks++;
        if (cnt0 !== 16'd2 || cnt1 !== 16'd2) begin
            $display("FAIL truth_table_counts: got %0d/%0d want 2/2", cnt0, cnt1);
            n_fail++;
        end
    endtask

    task automatic test_valid_gating();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b0);
            exp_v = sb_q.pop_front();
            got_v = observe();
            n_checks++;
            if (got_v !== exp_v) begin
                $display("FAIL valid_gating[%0d]: got %h want %h", i, got_v, exp_v);
                n_fail++;
            end
        end
        n_checks++;
        if (d1 !== 1'b1 || d1_valid !== 1'b0 || cnt1 !== 16'd2) begin
            $display("FAIL valid_gating_final: got d1=%b v=%b cnt1=%0d want 1 0 2",
                     d1, d1_valid, cnt1);
            n_fail++;
        end
    endtask

    task automatic test_saturation();
        logic [1:0] want [6];
        want = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        exp_v = sb_q.pop_front();
        got_v = observe();
        n_checks++;
        if (got_v !== exp_v) begin
            $display("FAIL sat_clear: got %h want %h", got_v, exp_v);
            n_fail++;
        end
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b0, 1'b1, 1'b0);
            exp_v = sb_q.pop_front();
            got_v = observe();
            n_checks++;
            if (got_v !== exp_v || s_cnt0 !== want[i]) begin
                $display("FAIL saturation[%0d]: got %h cnt0=%0d want %h cnt0=%0d",
                         i, got_v, s_cnt0, exp_v, want[i]);
                n_fail++;
            end
        end
    endtask

    task automatic test_clear_priority();
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        void'(sb_q.pop_front());
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, 1'b1, 1'b0);
            void'(sb_q.pop_front());
        end
        n_checks++;
        if (cnt0 !== 16'd5) begin
            $display("FAIL clear_setup: got cnt0=%0d want 5", cnt0);
            n_fail++;
        end
        drive(1'b1, 1'b0, 1'b1, 1'b1);
        exp_v = sb_q.pop_front();
        got_v = observe();
        n_checks++;
        if (got_v !== exp_v || cnt0 !== 16'd0 || d0_valid !== 1'b1) begin
            $display("FAIL clear_priority: got %h want %h", got_v, exp_v);
            n_fail++;
        end
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        exp_v = sb_q.pop_front();
        got_v = observe();
        n_checks++;
        if (got_v !== exp_v || cnt0 !== 16'd1) begin
            $display("FAIL clear_then_count: got %h cnt0=%0d want %h cnt0=1",
                     got_v, cnt0, exp_v);
            n_fail++;
        end
    endtask

    task automatic test_reset_mid();
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        void'(sb_q.pop_front());
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, 1'b1, 1'b1, 1'b0);
            void'(sb_q.pop_front());
        end
        n_checks++;
        if (cnt1 !== 16'd7 || d1 !== 1'b1) begin
            $display("FAIL reset_mid_setup: got cnt1=%0d d1=%b want 7 1", cnt1, d1);
            n_fail++;
        end
        #3 rst = 1'b1;
        #1;
        model_reset();
        n_checks++;
        if (cnt1 !== 16'd0 || d1 !== Byp || d1_valid !== 1'b0 || d0 !== 1'b0) begin
            $display("FAIL reset_mid: got cnt1=%0d d1=%b v1=%b d0=%b want 0 %b 0 0",
                     cnt1, d1, d1_valid, d0, Byp);
            n_fail++;
        end
        #1 rst = 1'b0;
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        exp_v = sb_q.pop_front();
        got_v = observe();
        n_checks++;
        if (got_v !== exp_v) begin
            $display("FAIL reset_mid_resume: got %h want %h", got_v, exp_v);
            n_fail++;
        end
    endtask

    task automatic test_back_to_back();
        logic ry, rs, rv, rc;
        for (int i = 0; i < 40; i++) begin
            ry = 1'($urandom_range(0, 1));
            rs = 1'($urandom_range(0, 1));
            rv = ($urandom_range(0, 3) != 0);
            rc = ($urandom_range(0, 7) == 0);
            drive(ry, rs, rv, rc);
            exp_v = sb_q.pop_front();
            got_v = observe();
            n_checks++;
            if (got_v !== exp_v) begin
                $display("FAIL back_to_back[%0d]: got %h want %h", i, got_v, exp_v);
                n_fail++;
            end
        end
    endtask

    initial begin
        m_c0 = '0; m_c1 = '0; m_s0 = '0; m_s1 = '0;
        test_reset();
        test_truth_table();
        test_valid_gating();
        test_saturation();
        test_clear_priority();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/demux_1to2.md
Name: demux_1to2

Overview:
- 1-to-2 demultiplexer with registered outputs: routes input word y to output d0 (sel=0) or d1 (sel=1); the unselected output is driven to zero.
- Adds per-channel valid flags and saturating per-channel transfer counters for debug and statistics.
- Used as a leaf routing element inside larger hierarchical datapaths.

Parameters:
- WIDTH, 1, bit width of y, d0 and d1.
- CNT_W, 16, bit width of each transfer counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- y  input  WIDTH  data to route.
- sel  input  1  0 selects d0, 1 selects d1.
- in_valid  input  1  qualifies y as a transfer for the valid flags and counters.
- clear_cnt  input  1  synchronous clear of both counters.
- d0  output  WIDTH  channel 0 data.
- d1  output  WIDTH  channel 1 data.
- d0_valid  output  1  channel 0 transfer flag.
- d1_valid  output  1  channel 1 transfer flag.
- cnt0  output  CNT_W  channel 0 transfer count.
- cnt1  output  CNT_W  channel 1 transfer count.

Behaviour:
- Reset: while rst=1, all outputs are 0 immediately, without waiting for a clock edge. The first update after reset release happens on the first rising clk edge.
- Routing happens every cycle, independent of in_valid. On each rising edge:
  - d0 <= (sel==0) ? y : 0
  - d1 <= (sel==1) ? y : 0
- Latency is exactly 1 cycle from y/sel to d0/d1.
- The unselected output is always all-zero. d0 and d1 are never both nonzero.
- Valid flags, registered in the same cycle as the data:
  - d0_valid <= in_valid & ~sel
  - d1_valid <= in_valid & sel
  - At most one flag is high in any cycle.
- Counters:
  - cnt0 increments on each clock edge where in_valid=1 and sel=0; cnt1 likewise for sel=1.
  - Both saturate at 2^CNT_W-1 and never wrap.
- clear_cnt=1 on a clock edge sets both counters to 0.
  - clear_cnt has priority over a simultaneous increment; that cycle's transfer is not counted.
  - clear_cnt does not affect d0, d1 or the valid flags.
- X/Z on sel is not supported; sel must be a clean 0/1 whenever in_valid=1.
- Asserting rst mid-stream discards any in-flight data. Counters and outputs return to 0 asynchronously.

Optional Feature:
- Macro DEMUX_COMB_BYPASS_EN.
- Defined: d0 and d1 are purely combinational, with zero latency (d0 = sel ? 0 : y; d1 = sel ? y : 0). They are not affected by rst.
  - Valid flags and counters remain registered and reset-controlled, as above.
- Undefined: registered 1-cycle data path exactly as specified in Behaviour.

Test Plan:
- Reset check: assert rst=1 with y=1, sel=1 and no clock edge -> all outputs read 0 at once. Release rst, clock once -> d1=1, d0=0.
- Truth table (WIDTH=1), in_valid=1, apply one vector per cycle and check one cycle later:
  - sel=0, y=0 -> d0=0, d1=0
  - sel=0, y=1 -> d0=1, d1=0
  - sel=1, y=0 -> d0=0, d1=0
  - sel=1, y=1 -> d0=0, d1=1
  - Expected after the four vectors: d0_valid high for the first two cycles, d1_valid for the last two, cnt0=2, cnt1=2.
- in_valid gating: sel=1, y=1, in_valid=0 for 3 cycles -> d1=1, d1_valid=0, cnt1 unchanged.
- Saturation: set CNT_W=2 and hold in_valid=1, sel=0 for 6 cycles -> cnt0 reads 1, 2, 3, 3, 3, 3.
- Clear priority: clear_cnt=1 together with in_valid=1, sel=0 while cnt0=5 -> next cycle cnt0=0. On the following valid sel=0 cycle -> cnt0=1.
- Reset mid-operation plus bypass: pulse rst asynchronously between clock edges while cnt1=7 -> cnt1 and d1 go to 0 immediately. With DEMUX_COMB_BYPASS_EN defined, sel=1, y=1 -> d1=1 in the same delta cycle, even while rst=1.
